// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative shift-add multiply / restoring divide with HI/LO registers
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_n;
  logic [CW-1:0] count;
  logic is_div, neg_q, neg_r, div_zero;
  // acc: upper product half (multiply) or partial remainder (divide)
  // q:   multiplier shifting out / dividend shifting out, quotient shifting in
  // m:   multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc, q, m;
  logic sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0] add_sum, rem_sh, trial;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // operand magnitudes, one iteration step for each op class, and final sign fix-up
  always_comb begin
    sgn = ~op[0];
    a_neg = sgn & srcA[WIDTH-1];
    b_neg = sgn & srcB[WIDTH-1];
    a_mag = a_neg ? -srcA : srcA;
    b_mag = b_neg ? -srcB : srcB;
    add_sum = q[0] ? {1'b0, acc} + {1'b0, m} : {1'b0, acc};
    rem_sh = {acc, q[WIDTH-1]};
    trial = rem_sh - {1'b0, m};
    prod = {acc, q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix = div_zero ? '1 : (neg_q ? -q : q);
    rem_fix = neg_r ? -acc : acc;
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  // next state and busy flag
  always_comb begin
    state_n = state;
    busy = state != IDLE;
    case (state)
      IDLE: state_n = start ? RUN : IDLE;
      RUN: state_n = (count == LAST) ? FIX : RUN;
      FIX: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // datapath: operand capture, iteration, result write-back and MTHI/MTLO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      acc <= '0;
      q <= '0;
      m <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            count <= '0;
            acc <= '0;
            q <= a_mag;
            m <= b_mag;
            is_div <= op[1];
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            div_zero <= srcB == '0;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (is_div) begin
            acc <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            q <= {q[WIDTH-2:0], ~trial[WIDTH]};
          end else begin
            acc <= add_sum[WIDTH:1];
            q <= {add_sum[0], q[WIDTH-1:1]};
          end
        end
        FIX: begin
          {hi, lo} <= is_div ? {rem_fix, quo_fix} : prod_fix;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
